// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone B4 pipelined initiator.
// Accepts one command on a valid/ready port, runs one bus beat, and returns
// read data or a timeout error on a valid/ready response port.
module wb_cmd_master #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  // command port
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_sel,
  // response port
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  // Wishbone initiator
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic [DW-1:0]   i_wb_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  // Counter value in the last cycle CYC may stay up without an ACK.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic        cmd_fire;
  logic        ack_ok;
  logic        expired;

  // CYC/STB and the handshake flags are pure decodes of the state register:
  // no i_wb_* path reaches an output, and async reset drops CYC/STB at once.
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign o_wb_cyc  = (state == S_REQ) || (state == S_WAIT);
  assign o_wb_stb  = (state == S_REQ);

  // Next-state decode: acceptance, qualified ACK and timeout detection.
  always_comb begin
    state_nxt = state;
    cmd_fire  = 1'b0;
    ack_ok    = 1'b0;
    expired   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_fire  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // an ACK during a stalled strobe is not a completion
        ack_ok  = !i_wb_stall && i_wb_ack;
        expired = !ack_ok && (cnt == TO_LAST);
        if (ack_ok || expired) begin
          state_nxt = S_RESP;
        end else if (!i_wb_stall) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        ack_ok  = i_wb_ack;
        expired = !i_wb_ack && (cnt == TO_LAST);
        if (ack_ok || expired) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timeout counter: cleared on command acceptance, counts while CYC is up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cmd_fire) begin
      cnt <= '0;
    end else if (o_wb_cyc) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Bus request registers: loaded on command acceptance, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_sel  <= '0;
    end else if (cmd_fire) begin
      o_wb_we   <= cmd_we;
      o_wb_addr <= cmd_addr;
      o_wb_data <= cmd_wdata;
      o_wb_sel  <= cmd_sel;
    end
  end

  // Response registers: captured on completion or timeout, held in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (ack_ok) begin
      rsp_rdata <= o_wb_we ? '0 : i_wb_data;
      rsp_err   <= 1'b0;
    end else if (expired) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed self-checking bench for wb_cmd_master.
module tb_wb_cmd_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [31:0]   cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_sel;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [31:0]   o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_stall;
  logic          i_wb_ack;
  logic [31:0]   i_wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] slave_mem [2];
  logic [31:0] ref_mem   [2];

  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Slave side of an ACK cycle: store writes / return read data.
  task automatic slave_respond(input logic [31:0] rd, input bit use_mem);
    if (o_wb_we) begin
      if (use_mem) slave_mem[o_wb_addr[2]] = merge(slave_mem[o_wb_addr[2]], o_wb_data, o_wb_sel);
      i_wb_data = 32'h0BAD_0BAD;
    end else begin
      i_wb_data = use_mem ? slave_mem[o_wb_addr[2]] : rd;
    end
  endtask

  // One command through the bus; leaves the DUT in RESP with rsp_ready low.
  task automatic bus_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel, input int stalls,
                         input int ack_dly, input logic [31:0] exp_rd, input bit use_mem);
    int stb_n = 0;
    int acc_n = 0;
    int bad_n = 0;
    logic stable;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_we = ~we; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_sel = ~sel;
    check({tag, ".req_lat"}, {o_wb_cyc, o_wb_stb, rsp_valid}, 3'b110);
    check({tag, ".addr"}, o_wb_addr, addr);
    check({tag, ".wdata"}, o_wb_data, wdata);
    check({tag, ".we_sel"}, {o_wb_we, o_wb_sel}, {we, sel});
    for (int i = 0; i < stalls; i++) begin
      i_wb_stall = 1'b1;
      i_wb_ack   = (i == 1);
      i_wb_data  = 32'hFFFF_0000;
      stable = (o_wb_addr === addr) && (o_wb_data === wdata) && (o_wb_we === we) && (o_wb_sel === sel);
      if (o_wb_stb && o_wb_cyc && stable) stb_n++; else bad_n++;
      tick();
    end
    i_wb_stall = 1'b0;
    i_wb_ack   = (ack_dly == 0);
    if (ack_dly == 0) slave_respond(exp_rd, use_mem);
    stable = (o_wb_addr === addr) && (o_wb_data === wdata) && (o_wb_we === we) && (o_wb_sel === sel);
    if (o_wb_stb && o_wb_cyc && stable) acc_n++; else bad_n++;
    tick();
    i_wb_ack  = 1'b0;
    i_wb_data = 32'hBAD0_BAD0;
    if (ack_dly > 0) begin
      for (int d = 1; d < ack_dly; d++) begin
        if (!(o_wb_cyc && !o_wb_stb && o_wb_addr === addr)) bad_n++;
        tick();
      end
      i_wb_ack = 1'b1;
      slave_respond(exp_rd, use_mem);
      if (!(o_wb_cyc && !o_wb_stb && o_wb_addr === addr)) bad_n++;
      tick();
      i_wb_ack  = 1'b0;
      i_wb_data = 32'hBAD0_BAD0;
    end
    check({tag, ".stall_stb"}, stb_n, stalls);
    check({tag, ".accepts"}, acc_n, 1);
    check({tag, ".bus_bad"}, bad_n, 0);
    check({tag, ".resp"}, {o_wb_cyc, o_wb_stb, rsp_valid, rsp_err, cmd_ready}, 5'b00100);
    check({tag, ".rdata"}, rsp_rdata, we ? 32'h0 : exp_rd);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".consumed"}, {rsp_valid, cmd_ready, o_wb_cyc}, 3'b010);
  endtask

  initial begin
    int n;
    int bad;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
    int          stl;
    int          dly;

    reset = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_sel = '0; rsp_ready = 1'b0; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_data = '0;
    slave_mem[0] = 32'h1111_1111; slave_mem[1] = 32'h2222_2222;
    ref_mem[0]   = 32'h1111_1111; ref_mem[1]   = 32'h2222_2222;

    // reset state
    #1 reset = 1'b1;
    #1;
    check("rst.ctrl", {cmd_ready, rsp_valid, rsp_err, o_wb_cyc, o_wb_stb, o_wb_we}, 6'b100000);
    check("rst.addr_data", {o_wb_addr, o_wb_data}, 64'h0);
    check("rst.sel_rdata", {o_wb_sel, rsp_rdata}, 36'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // stray ACK in IDLE
    i_wb_ack = 1'b1;
    tick(); tick();
    i_wb_ack = 1'b0;
    check("idle_ack", {cmd_ready, rsp_valid, o_wb_cyc, o_wb_stb}, 4'b1000);

    // 1: write to zero-wait slave
    bus_txn("t1", 1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 0, 0, 32'h0, 1'b0);
    consume("t1");

    // 2: read, 3 stalls, ACK 2 cycles after acceptance
    bus_txn("t2", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 2, 32'hDEAD_BEEF, 1'b0);

    // 4: response backpressure with a pending command
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0008; cmd_wdata = '0; cmd_sel = 4'hF;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, cmd_ready, o_wb_cyc} !== 3'b100 || rsp_rdata !== 32'hDEAD_BEEF) bad++;
      tick();
    end
    check("t4.hold", bad, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t4.no_bypass", {rsp_valid, cmd_ready, o_wb_cyc, o_wb_stb}, 4'b0100);
    tick();
    cmd_valid = 1'b0;
    check("t4.accepted", {o_wb_cyc, o_wb_stb}, 2'b11);
    check("t4.addr", o_wb_addr, 32'h3000_0008);
    i_wb_ack = 1'b1; i_wb_data = 32'h0BAD_F00D;
    tick();
    i_wb_ack = 1'b0; i_wb_data = '0;
    check("t4.resp", {rsp_valid, rsp_err}, 2'b10);
    check("t4.rdata", rsp_rdata, 32'h0BAD_F00D);
    consume("t4");

    // 3: timeout, slave never ACKs
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0000;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (o_wb_cyc && n < 20) begin
      n++;
      tick();
    end
    check("t3.cyc_cycles", n, TO);
    check("t3.resp", {o_wb_cyc, o_wb_stb, rsp_valid, rsp_err}, 4'b0011);
    check("t3.rdata", rsp_rdata, 32'h0);
    consume("t3");
    bus_txn("t3b", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 1, 32'hCAFE_F00D, 1'b0);
    consume("t3b");
    // ACK in the last permitted cycle wins over timeout
    bus_txn("t3c", 1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 7, 32'h7777_0007, 1'b0);
    consume("t3c");

    // 5: reset while waiting for ACK
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0004;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t5.in_wait", {o_wb_cyc, o_wb_stb}, 2'b10);
    #1 reset = 1'b1;
    #1;
    check("t5.async", {o_wb_cyc, o_wb_stb, rsp_valid, cmd_ready}, 4'b0001);
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    i_wb_ack = 1'b1; i_wb_data = 32'h5555_5555;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      i_wb_ack = 1'b0;
      if (rsp_valid || o_wb_cyc || !cmd_ready) bad++;
    end
    rsp_ready = 1'b0;
    check("t5.no_resp", bad, 0);

    // 6: back-to-back alternating write/read against a reference memory
    for (int unsigned k = 0; k < 4; k++) begin
      we   = (k % 2 == 0);
      addr = (k < 2) ? 32'h3000_0000 : 32'h3000_0004;
      sel  = (k < 2) ? 4'hF : 4'b0101;
      wd   = $urandom;
      stl  = int'($urandom_range(0, 3));
      dly  = int'($urandom_range(0, 3));
      if (we) begin
        ref_mem[addr[2]] = merge(ref_mem[addr[2]], wd, sel);
        exp = 32'h0;
      end else begin
        exp = ref_mem[addr[2]];
      end
      bus_txn($sformatf("t6.%0d", k), we, addr, wd, sel, stl, dly, exp, 1'b1);
      consume($sformatf("t6.%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
